// File: rtl/fetch_unit_if.sv
// Interface: fetch_unit_if
// Groups the instruction-memory bus and the decode-side valid/ready bus of the
// fetch stage.
//   imem_addr  8   fetch address to instruction memory
//   imem_inst  32  memory read data (one cycle after the address)
//   out_valid  1   head of fetch buffer is valid
//   out_ready  1   decode accepts the head this cycle
//   out_pc     8   PC of head instruction
//   out_inst   32  head instruction word
// master = fetch unit side, slave = memory/decode side.
interface fetch_unit_if;
    logic [7:0]  imem_addr;
    logic [31:0] imem_inst;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_pc;
    logic [31:0] out_inst;

    modport master (
        output imem_addr,
        input  imem_inst,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_inst
    );

    modport slave (
        input  imem_addr,
        output imem_inst,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_inst
    );
endinterface

// File: rtl/fetch_unit.sv
// Module: fetch_unit
// Instruction-fetch stage in front of a 1-cycle-latency instruction memory.
// Holds the PC, issues fetches, captures returned words with their PC into a
// 2-entry buffer and hands (pc, inst) pairs to decode over valid/ready.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start            pulse, IDLE/HALT -> RUN
//   halt_req         pulse, RUN -> HALT (wins over start)
//   redirect_valid   load redirect_pc and flush in-flight/buffered fetches
//   redirect_pc      new PC on redirect
//   busy             RUN, fetch in flight, or buffer non-empty
//   bus              fetch_unit_if.master (memory + decode buses)
//
// state | meaning
// IDLE  | out of reset, no fetching
// RUN   | issuing fetches while buffer space allows
// HALT  | no new fetches, in-flight word still captured, buffer drains
module fetch_unit #(
    parameter logic [7:0] RESET_PC = 8'd0,
    parameter logic [7:0] PC_STEP  = 8'd1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              halt_req,
    input  logic              redirect_valid,
    input  logic [7:0]        redirect_pc,
    output logic              busy,
    fetch_unit_if.master      bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [7:0]  pc;
    logic [7:0]  req_pc_q;
    logic        req_valid_q;
    logic [7:0]  buf_pc   [2];
    logic [31:0] buf_inst [2];
    logic        head;
    logic        tail;
    logic [1:0]  count;
    logic        pop;
    logic        push;
    logic        issue;
    logic [2:0]  occupancy;

    assign bus.imem_addr = pc;
    assign bus.out_valid = (count != 2'd0);
    assign bus.out_pc    = buf_pc[head];
    assign bus.out_inst  = buf_inst[head];

    // A redirect discards both the popped head and the returning word.
    assign pop  = bus.out_valid & bus.out_ready & ~redirect_valid;
    assign push = req_valid_q & ~redirect_valid;

    // Entries the buffer will hold after this edge, counting the word in flight;
    // issuing only when this is <= 1 guarantees room when the new word returns.
    assign occupancy = {1'b0, count} + {2'b00, req_valid_q} - {2'b00, pop};
    assign issue     = (state == ST_RUN) & ~redirect_valid & (occupancy <= 3'd1);

    assign busy = (state == ST_RUN) | req_valid_q | (count != 2'd0);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start && !halt_req) state_nxt = ST_RUN;
            ST_RUN:  if (halt_req)           state_nxt = ST_HALT;
            ST_HALT: if (start && !halt_req) state_nxt = ST_RUN;
            default:                         state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            req_pc_q    <= 8'd0;
            req_valid_q <= 1'b0;
        end else begin
            req_valid_q <= issue;
            if (redirect_valid) begin
                pc <= redirect_pc;
            end else if (issue) begin
                req_pc_q <= pc;
                pc       <= pc + PC_STEP;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                buf_pc[i]   <= 8'd0;
                buf_inst[i] <= 32'd0;
            end
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
        end else if (redirect_valid) begin
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                buf_pc[tail]   <= req_pc_q;
                buf_inst[tail] <= bus.imem_inst;
                tail           <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Testbench: tb_fetch_unit
// Directed stimulus around fetch_unit with a registered instruction-memory
// model. Expected (pc, inst) pairs go into a queue as stimulus is issued; a
// monitor pops and compares on every accepted output.
module tb_fetch_unit;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic       halt_req;
    logic       redirect_valid;
    logic [7:0] redirect_pc;
    logic       busy;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(8'd0), .PC_STEP(8'd1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .halt_req       (halt_req),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .busy           (busy),
        .bus            (bus.master)
    );

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    int pops_before;
    logic [39:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_val(input logic [7:0] a);
        if (a == 8'd150) return 32'd20;
        return 32'hA0 + {24'h0, a};
    endfunction

    always @(posedge clk) bus.imem_inst <= mem_val(bus.imem_addr);

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_seq(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] p;
            p = first + 8'(i);
            exp_q.push_back({p, mem_val(p)});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: an output is consumed when valid & ready at the edge.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready && !redirect_valid) begin
            pops++;
            if (exp_q.size() == 0) begin
                check("unexpected_output", {bus.out_pc, bus.out_inst}, 40'hFF_FFFF_FFFF);
            end else begin
                check("stream_order", {bus.out_pc, bus.out_inst}, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        start          = 1'b0;
        halt_req       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'd0;
        bus.out_ready  = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("rst_out_valid", 40'(bus.out_valid), 40'd0);
        check("rst_busy",      40'(busy),          40'd0);
        check("rst_imem_addr", 40'(bus.imem_addr), 40'd0);
        check("rst_out_pc",    {bus.out_pc, bus.out_inst}, 40'd0);

        // Reset mid-operation
        push_seq(8'd0, 40);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        check("pre_rst_valid", 40'(bus.out_valid), 40'd1);
        check("pre_rst_addr",  40'(bus.imem_addr), 40'd10);
        check("pre_rst_pc",    40'(bus.out_pc),    40'd8);
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("async_rst_valid", 40'(bus.out_valid), 40'd0);
        check("async_rst_busy",  40'(busy),          40'd0);
        check("async_rst_addr",  40'(bus.imem_addr), 40'd0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("post_rst_valid", 40'(bus.out_valid), 40'd0);
        check("post_rst_busy",  40'(busy),          40'd0);
        check("post_rst_addr",  40'(bus.imem_addr), 40'd0);

        // Stream and start latency
        push_seq(8'd0, 40);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("lat_e0_valid", 40'(bus.out_valid), 40'd0);
        tick();
        check("lat_e1_valid", 40'(bus.out_valid), 40'd0);
        tick();
        check("lat_e2_valid", 40'(bus.out_valid), 40'd1);
        check("stream_0", {bus.out_pc, bus.out_inst}, {8'd0, 32'hA0});
        for (int i = 1; i < 4; i++) begin
            tick();
            check("stream_n", {bus.out_pc, bus.out_inst}, {8'(i), 32'hA0 + 32'(i)});
        end

        // Backpressure
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("bp_head",  40'(bus.out_pc),    40'd3);
            check("bp_addr",  40'(bus.imem_addr), 40'd5);
            check("bp_valid", 40'(bus.out_valid), 40'd1);
        end
        bus.out_ready = 1'b1;
        for (int i = 4; i < 8; i++) begin
            tick();
            check("bp_release_valid", 40'(bus.out_valid), 40'd1);
            check("bp_release_pc",    40'(bus.out_pc),    40'(i));
        end

        // Redirect with full buffer
        bus.out_ready = 1'b0;
        repeat (2) tick();
        check("full_head", 40'(bus.out_pc), 40'd7);
        redirect_valid = 1'b1;
        redirect_pc    = 8'd150;
        bus.out_ready  = 1'b1;
        tick();
        redirect_valid = 1'b0;
        exp_q.delete();
        push_seq(8'd150, 8);
        check("redir_flush_valid", 40'(bus.out_valid), 40'd0);
        tick();
        check("redir_inflight_valid", 40'(bus.out_valid), 40'd0);
        tick();
        check("redir_first", {bus.out_pc, bus.out_inst}, {8'd150, 32'd20});
        tick();
        check("redir_second", 40'(bus.out_pc), 40'd151);

        // PC wrap
        redirect_valid = 1'b1;
        redirect_pc    = 8'd255;
        tick();
        redirect_valid = 1'b0;
        exp_q.delete();
        push_seq(8'd255, 8);
        repeat (2) tick();
        check("wrap_255", {bus.out_pc, bus.out_inst}, {8'd255, 32'h19F});
        tick();
        check("wrap_0", 40'(bus.out_pc), 40'd0);
        tick();
        check("wrap_1", 40'(bus.out_pc), 40'd1);

        // Halt and drain
        halt_req    = 1'b1;
        pops_before = pops;
        tick();
        halt_req = 1'b0;
        check("halt_d1_pc",   40'(bus.out_pc),    40'd2);
        check("halt_d1_addr", 40'(bus.imem_addr), 40'd4);
        check("halt_d1_busy", 40'(busy),          40'd1);
        tick();
        check("halt_d2_pc",   40'(bus.out_pc),    40'd3);
        check("halt_d2_busy", 40'(busy),          40'd1);
        tick();
        check("halt_empty_valid", 40'(bus.out_valid), 40'd0);
        check("halt_empty_busy",  40'(busy),          40'd0);
        repeat (4) tick();
        check("halt_pop_count", 40'(pops - pops_before), 40'd3);
        check("halt_addr_held", 40'(bus.imem_addr),      40'd4);

        // Restart from HALT
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        check("restart_head", {bus.out_pc, bus.out_inst}, {8'd4, 32'hA4});

        // halt_req wins over start
        halt_req    = 1'b1;
        start       = 1'b1;
        pops_before = pops;
        tick();
        halt_req = 1'b0;
        start    = 1'b0;
        repeat (5) tick();
        check("prio_valid",     40'(bus.out_valid),      40'd0);
        check("prio_busy",      40'(busy),               40'd0);
        check("prio_addr",      40'(bus.imem_addr),      40'd7);
        check("prio_pop_count", 40'(pops - pops_before), 40'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
